// File: rtl/bus_s_arb.sv
// Registered S-bus merger: round-robin req/gnt arbiter with burst lock (ARB_EN=1)
// or legacy registered OR-merge (ARB_EN=0). Define BUS_S_COLLISION_EN for the sticky collision flag.
module bus_s_arb #(
  parameter int WIDTH  = 16,
  parameter int N_SRC  = 6,
  parameter int ARB_EN = 1,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC-1:0]       lock,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [N_SRC-1:0]       gnt,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [SRC_W-1:0]       bus_src,
  input  logic                   err_clr,
  output logic                   bus_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_SRC - 1);

  state_t           state, state_next;
  logic [SRC_W-1:0] ptr, ptr_next;
  logic [SRC_W-1:0] owner, owner_next;

  logic [N_SRC-1:0] gnt_next;
  logic [WIDTH-1:0] bus_out_next;
  logic             bus_valid_next;
  logic [SRC_W-1:0] bus_src_next;

  logic [SRC_W-1:0] winner;
  logic             win_found;
  logic [SRC_W-1:0] lowest_req;
  logic [WIDTH-1:0] or_data;
  logic [WIDTH-1:0] owner_data;

  // Round-robin search starting at ptr, wrapping explicitly at N_SRC-1
  always_comb begin
    int j;
    j         = 0;
    winner    = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      j = int'(ptr) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        winner    = SRC_W'(j);
      end
    end
  end

  always_comb begin
    lowest_req = '0;
    or_data    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) lowest_req = SRC_W'(i);
      or_data = or_data | src_data[i*WIDTH +: WIDTH];
    end
  end

  assign owner_data = src_data[int'(owner)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      gnt       <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      owner     <= owner_next;
      gnt       <= gnt_next;
      bus_out   <= bus_out_next;
      bus_valid <= bus_valid_next;
      bus_src   <= bus_src_next;
    end
  end

  // No preemption: while in GRANT only the owner's req/lock are looked at
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    if (ARB_EN != 0) begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state_next = GRANT;
            owner_next = winner;
          end
        end
        GRANT: begin
          if (!(req[owner] && lock[owner])) begin
            state_next = IDLE;
            ptr_next   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    gnt_next       = '0;
    bus_out_next   = bus_out;
    bus_valid_next = 1'b0;
    bus_src_next   = bus_src;
    if (ARB_EN == 0) begin
      gnt_next       = req;
      bus_out_next   = or_data;
      bus_valid_next = |req;
      bus_src_next   = lowest_req;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) gnt_next = N_SRC'(1) << winner;
        end
        GRANT: begin
          if (req[owner]) begin
            bus_out_next   = owner_data;
            bus_valid_next = 1'b1;
            bus_src_next   = owner;
            if (lock[owner]) gnt_next = gnt;
          end
        end
        default: gnt_next = '0;
      endcase
    end
  end

`ifdef BUS_S_COLLISION_EN
  logic collision;

  always_comb begin
    int nonzero;
    nonzero   = 0;
    collision = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_data[i*WIDTH +: WIDTH] != '0) begin
        nonzero = nonzero + 1;
        if ((ARB_EN != 0) && (gnt != '0) && !gnt[i]) collision = 1'b1;
      end
    end
    if ((ARB_EN == 0) && (nonzero > 1)) collision = 1'b1;
  end

  // Sticky flag; a fresh collision wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bus_err <= 1'b0;
    else if (collision) bus_err <= 1'b1;
    else if (err_clr)   bus_err <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_bus_s_arb.sv
// Scoreboard bench for bus_s_arb: arbiter instance (ARB_EN=1) plus OR-merge instance (ARB_EN=0).
module tb_bus_s_arb;

  typedef struct {
    string      tag;
    bit         dutSel;
    logic [5:0] gnt;
    logic       valid;
    logic [15:0] data;
    logic [2:0] src;
  } expect_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  req, lock;
  logic [95:0] srcData;
  logic [5:0]  gnt;
  logic [15:0] busOut;
  logic        busValid;
  logic [2:0]  busSrc;
  logic        errClr;
  logic        busErr;

  logic [5:0]  orReq;
  logic [95:0] orData;
  logic [5:0]  orGnt;
  logic [15:0] orBusOut;
  logic        orBusValid;
  logic [2:0]  orBusSrc;
  logic        orBusErr;

  int checks;
  int failures;
  expect_t sb[$];

  bus_s_arb #(.WIDTH(16), .N_SRC(6), .ARB_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .src_data(srcData),
    .gnt(gnt), .bus_out(busOut), .bus_valid(busValid), .bus_src(busSrc),
    .err_clr(errClr), .bus_err(busErr)
  );

  bus_s_arb #(.WIDTH(16), .N_SRC(6), .ARB_EN(0)) dutOr (
    .clk(clk), .rst_n(rst_n), .req(orReq), .lock(6'b0), .src_data(orData),
    .gnt(orGnt), .bus_out(orBusOut), .bus_valid(orBusValid), .bus_src(orBusSrc),
    .err_clr(1'b0), .bus_err(orBusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the selected instance
  task automatic compareNext();
    expect_t e;
    checkOutput("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (!e.dutSel) begin
      checkOutput({e.tag, ".gnt"},   32'(gnt),      32'(e.gnt));
      checkOutput({e.tag, ".valid"}, 32'(busValid), 32'(e.valid));
      checkOutput({e.tag, ".data"},  32'(busOut),   32'(e.data));
      checkOutput({e.tag, ".src"},   32'(busSrc),   32'(e.src));
    end else begin
      checkOutput({e.tag, ".gnt"},   32'(orGnt),      32'(e.gnt));
      checkOutput({e.tag, ".valid"}, 32'(orBusValid), 32'(e.valid));
      checkOutput({e.tag, ".data"},  32'(orBusOut),   32'(e.data));
      checkOutput({e.tag, ".src"},   32'(orBusSrc),   32'(e.src));
    end
  endtask

  task automatic applyStimulus(input logic [5:0] r, input logic [5:0] l, input string tag,
                               input logic [5:0] eg, input logic ev, input logic [15:0] ed,
                               input logic [2:0] es);
    req  = r;
    lock = l;
    sb.push_back('{tag, 1'b0, eg, ev, ed, es});
    @(posedge clk); #1;
    compareNext();
  endtask

  task automatic applyOrStimulus(input logic [5:0] r, input string tag, input logic [5:0] eg,
                                 input logic ev, input logic [15:0] ed, input logic [2:0] es);
    orReq = r;
    sb.push_back('{tag, 1'b1, eg, ev, ed, es});
    @(posedge clk); #1;
    compareNext();
  endtask

  task automatic setData(input int idx, input logic [15:0] v);
    srcData[idx*16 +: 16] = v;
  endtask

  initial begin
    logic [15:0] lastData;
    logic [2:0]  lastSrc;
    int order[7];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    lock     = '0;
    errClr   = 1'b0;
    orReq    = '0;
    orData   = '0;
    srcData  = '0;
    for (int i = 0; i < 6; i++) setData(i, 16'h00A0 + 16'(i));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.gnt",   32'(gnt),      32'd0);
    checkOutput("rst.valid", 32'(busValid), 32'd0);
    checkOutput("rst.data",  32'(busOut),   32'd0);
    checkOutput("rst.src",   32'(busSrc),   32'd0);
    checkOutput("rst.err",   32'(busErr),   32'd0);
    checkOutput("rst.orGnt", 32'(orGnt),    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin with all requests held, grant then transfer per source
    order    = '{0, 1, 2, 3, 4, 5, 0};
    lastData = 16'h0000;
    lastSrc  = 3'd0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(6'b111111, 6'b0, $sformatf("rr%0d.g", k),
                    6'(1) << order[k], 1'b0, lastData, lastSrc);
      lastData = 16'h00A0 + 16'(order[k]);
      lastSrc  = 3'(order[k]);
      applyStimulus(6'b111111, 6'b0, $sformatf("rr%0d.t", k),
                    6'b0, 1'b1, lastData, lastSrc);
    end

    // Reset in the middle of a locked burst from src2
    applyStimulus(6'b000100, 6'b000100, "mid.g", 6'b000100, 1'b0, 16'h00A0, 3'd0);
    applyStimulus(6'b000100, 6'b000100, "mid.t", 6'b000100, 1'b1, 16'h00A2, 3'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.gnt",   32'(gnt),      32'd0);
    checkOutput("midrst.valid", 32'(busValid), 32'd0);
    req  = '0;
    lock = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(6'b000011, 6'b0, "ptr0.g", 6'b000001, 1'b0, 16'h0000, 3'd0);
    applyStimulus(6'b000011, 6'b0, "ptr0.t", 6'b000000, 1'b1, 16'h00A0, 3'd0);
    applyStimulus(6'b000100, 6'b0, "s2.g",   6'b000100, 1'b0, 16'h00A0, 3'd0);
    applyStimulus(6'b000100, 6'b0, "s2.t",   6'b000000, 1'b1, 16'h00A2, 3'd2);

    // Burst from src3 while src1 waits
    applyStimulus(6'b001010, 6'b001000, "bst.g", 6'b001000, 1'b0, 16'h00A2, 3'd2);
    for (int w = 1; w <= 4; w++) begin
      setData(3, 16'(w));
      applyStimulus(6'b001010, 6'b001000, $sformatf("bst.w%0d", w),
                    6'b001000, 1'b1, 16'(w), 3'd3);
    end
    setData(3, 16'd5);
    applyStimulus(6'b001010, 6'b000000, "bst.w5",  6'b000000, 1'b1, 16'd5, 3'd3);
    applyStimulus(6'b001010, 6'b000000, "bst.s1g", 6'b000010, 1'b0, 16'd5, 3'd3);
    applyStimulus(6'b000010, 6'b000000, "bst.s1t", 6'b000000, 1'b1, 16'h00A1, 3'd1);

    // Withdrawal by src4, then src5 wins from ptr=5
    applyStimulus(6'b010000, 6'b0, "wd.g",   6'b010000, 1'b0, 16'h00A1, 3'd1);
    applyStimulus(6'b000000, 6'b0, "wd.drop", 6'b000000, 1'b0, 16'h00A1, 3'd1);
    applyStimulus(6'b100001, 6'b0, "wd.s5g", 6'b100000, 1'b0, 16'h00A1, 3'd1);
    applyStimulus(6'b100001, 6'b0, "wd.s5t", 6'b000000, 1'b1, 16'h00A5, 3'd5);

    // Collision detection on the arbiter instance
    srcData = '0;
    errClr  = 1'b1;
    applyStimulus(6'b0, 6'b0, "col.clr", 6'b0, 1'b0, 16'h00A5, 3'd5);
    errClr  = 1'b0;
    checkOutput("col.init", 32'(busErr), 32'd0);
    setData(1, 16'h0011);
    applyStimulus(6'b000010, 6'b000010, "col.g", 6'b000010, 1'b0, 16'h00A5, 3'd5);
    setData(2, 16'h0001);
    applyStimulus(6'b000010, 6'b000010, "col.t", 6'b000010, 1'b1, 16'h0011, 3'd1);
`ifdef BUS_S_COLLISION_EN
    checkOutput("col.set", 32'(busErr), 32'd1);
`else
    checkOutput("col.off", 32'(busErr), 32'd0);
`endif
    setData(2, 16'h0000);
    applyStimulus(6'b000010, 6'b000000, "col.end", 6'b000000, 1'b1, 16'h0011, 3'd1);
    applyStimulus(6'b000000, 6'b000000, "col.idl", 6'b000000, 1'b0, 16'h0011, 3'd1);
`ifdef BUS_S_COLLISION_EN
    checkOutput("col.sticky", 32'(busErr), 32'd1);
`endif
    errClr = 1'b1;
    @(posedge clk); #1;
    errClr = 1'b0;
    checkOutput("col.cleared", 32'(busErr), 32'd0);

    // OR-merge instance
    orData[0*16 +: 16] = 16'h00F0;
    orData[5*16 +: 16] = 16'h0F00;
    applyOrStimulus(6'b100001, "or.a", 6'b100001, 1'b1, 16'h0FF0, 3'd0);
    applyOrStimulus(6'b000000, "or.b", 6'b000000, 1'b0, 16'h0FF0, 3'd0);
    orData[2*16 +: 16] = 16'h0003;
    applyOrStimulus(6'b010100, "or.c", 6'b010100, 1'b1, 16'h0FF3, 3'd2);
    applyOrStimulus(6'b100000, "or.d", 6'b100000, 1'b1, 16'h0FF3, 3'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
